// File: rtl/bp_pkg.sv
// Shared types, counter encodings and PC field extraction for the branch predictor.
package bp_pkg;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    // Tag field is sized for the narrowest index; with wider indices the
    // upper tag bits are simply always zero.
    typedef struct packed {
        logic        valid;
        logic [29:0] tag;
        logic [29:0] target;
        logic [1:0]  ctr;
    } bp_entry_t;

    function automatic logic [29:0] pc_idx(input logic [31:0] pc, input int idx_bits);
        return pc[31:2] & ((30'd1 << idx_bits) - 30'd1);
    endfunction

    function automatic logic [29:0] pc_tag(input logic [31:0] pc, input int idx_bits);
        return pc[31:2] >> idx_bits;
    endfunction

endpackage

// File: rtl/bp_sat_ctr.sv
// 2-bit saturating counter next-state: count up on taken, down on not-taken.
module bp_sat_ctr
    import bp_pkg::*;
(
    input  logic [1:0] ctr,
    input  logic       taken,
    output logic [1:0] ctr_n
);

    // Saturate at ST going up and SNT going down.
    always_comb begin
        ctr_n = ctr;
        if (taken) begin
            if (ctr != ST) ctr_n = ctr + 2'd1;
        end else begin
            if (ctr != SNT) ctr_n = ctr - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BHT + BTB beside fetch. Lookup is combinational; training goes
// through a one-entry update register and is bypassed to lookup while pending.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int IDX_BITS = 4
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic [31:0] fetch_pc,
    output logic        pred_hit,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        br,
    input  logic        br_result,
    input  logic        br_pred,
    input  logic [31:0] br_pc,
    input  logic [31:0] br_target,
    input  logic        clear,
    output logic [31:0] br_cnt,
    output logic [31:0] miss_cnt
);

    localparam int ENTRIES  = 2 ** IDX_BITS;
    localparam int TAG_BITS = 30 - IDX_BITS;

    bp_entry_t tbl [ENTRIES];

    logic                upd_v;
    logic                upd_result;
    logic [IDX_BITS-1:0] upd_idx;
    logic [TAG_BITS-1:0] upd_tag;
    logic [29:0]         upd_target;

    bp_entry_t           upd_old, upd_new, look;
    logic                upd_hit, upd_we;
    logic [1:0]          ctr_n;
    logic [IDX_BITS-1:0] fetch_idx;
    logic [TAG_BITS-1:0] fetch_tag;
    logic                unused_pc_lsbs;

    // Word-offset bits of resolved PCs play no part in indexing or targets.
    assign unused_pc_lsbs = ^{br_pc[1:0], br_target[1:0]};

    assign fetch_idx = IDX_BITS'(pc_idx(fetch_pc, IDX_BITS));
    assign fetch_tag = TAG_BITS'(pc_tag(fetch_pc, IDX_BITS));

    assign upd_old = tbl[upd_idx];
    assign upd_hit = upd_old.valid && (upd_old.tag == 30'(upd_tag));

    bp_sat_ctr u_sat_ctr (
        .ctr   (upd_old.ctr),
        .taken (upd_result),
        .ctr_n (ctr_n)
    );

    // Post-update value of the pending entry; equals the old entry when nothing is written.
    always_comb begin
        upd_new = upd_old;
        upd_we  = 1'b0;
        if (upd_v) begin
            if (upd_hit) begin
                upd_we      = 1'b1;
                upd_new.ctr = ctr_n;
                if (upd_result) upd_new.target = upd_target;
            end else if (upd_result) begin
                upd_we  = 1'b1;
                upd_new = '{valid: 1'b1, tag: 30'(upd_tag), target: upd_target, ctr: WT};
            end
        end
    end

    // Lookup, forwarding the pending update so fetch never sees a stale entry.
    always_comb begin
        look = tbl[fetch_idx];
        if (upd_v && (fetch_idx == upd_idx)) look = upd_new;
        pred_hit    = look.valid && (look.tag == 30'(fetch_tag));
        pred_taken  = pred_hit && look.ctr[1];
        pred_target = pred_taken ? {look.target, 2'b00} : fetch_pc + 32'd4;
    end

    // Table storage: clear invalidates everything and wins over a pending write.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < ENTRIES; i++)
                tbl[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: WNT};
        end else if (clear) begin
            for (int i = 0; i < ENTRIES; i++) begin
                tbl[i].valid <= 1'b0;
                tbl[i].ctr   <= WNT;
            end
        end else if (upd_we) begin
            tbl[upd_idx] <= upd_new;
        end
    end

    // Update register: captures a resolving branch; clear drops both pending and new.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            upd_v      <= 1'b0;
            upd_result <= 1'b0;
            upd_idx    <= '0;
            upd_tag    <= '0;
            upd_target <= '0;
        end else if (clear) begin
            upd_v <= 1'b0;
        end else begin
            upd_v <= br;
            if (br) begin
                upd_result <= br_result;
                upd_idx    <= IDX_BITS'(pc_idx(br_pc, IDX_BITS));
                upd_tag    <= TAG_BITS'(pc_tag(br_pc, IDX_BITS));
                upd_target <= br_target[31:2];
            end
        end
    end

    // Saturating statistics; they count every resolution, even one lost to clear.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            br_cnt   <= '0;
            miss_cnt <= '0;
        end else if (br) begin
            if (br_cnt != 32'hFFFF_FFFF) br_cnt <= br_cnt + 32'd1;
            if ((br_result != br_pred) && (miss_cnt != 32'hFFFF_FFFF))
                miss_cnt <= miss_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: an immediate-update reference model checked every
// cycle, plus directed steps with hand-computed literal expectations.
module tb_branch_predictor;

    localparam int IB = 4;
    localparam int N  = 16;

    logic        CLK, nRST;
    logic [31:0] fetch_pc;
    logic        pred_hit, pred_taken;
    logic [31:0] pred_target;
    logic        br, br_result, br_pred, clear;
    logic [31:0] br_pc, br_target;
    logic [31:0] br_cnt, miss_cnt;

    branch_predictor #(.IDX_BITS(IB)) dut (
        .CLK(CLK), .nRST(nRST), .fetch_pc(fetch_pc),
        .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
        .br(br), .br_result(br_result), .br_pred(br_pred), .br_pc(br_pc),
        .br_target(br_target), .clear(clear), .br_cnt(br_cnt), .miss_cnt(miss_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a resolved branch takes effect as soon as it is seen,
    // which is what the outputs must look like from the following cycle on.
    bit          m_valid [N];
    int unsigned m_tag   [N];
    logic [31:0] m_tgt   [N];
    int          m_ctr   [N];
    logic [31:0] m_br, m_miss;

    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < N; i++) begin
                m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 1;
            end
            m_br = 0; m_miss = 0;
        end else begin
            if (br) begin
                if (m_br != 32'hFFFF_FFFF) m_br = m_br + 1;
                if (br_result != br_pred && m_miss != 32'hFFFF_FFFF) m_miss = m_miss + 1;
            end
            if (clear) begin
                for (int i = 0; i < N; i++) begin
                    m_valid[i] = 0; m_ctr[i] = 1;
                end
            end else if (br) begin
                int k;
                int unsigned t;
                k = (br_pc >> 2) % N;
                t = br_pc >> (IB + 2);
                if (m_valid[k] && m_tag[k] == t) begin
                    if (br_result) begin
                        m_ctr[k] = (m_ctr[k] == 3) ? 3 : m_ctr[k] + 1;
                        m_tgt[k] = {br_target[31:2], 2'b00};
                    end else begin
                        m_ctr[k] = (m_ctr[k] == 0) ? 0 : m_ctr[k] - 1;
                    end
                end else if (br_result) begin
                    m_valid[k] = 1; m_tag[k] = t;
                    m_tgt[k] = {br_target[31:2], 2'b00}; m_ctr[k] = 2;
                end
            end
        end
    end

    // Compare every output against the model, mid-cycle.
    always @(negedge CLK) begin
        int k;
        bit e_hit, e_tk;
        k     = (fetch_pc >> 2) % N;
        e_hit = m_valid[k] && (m_tag[k] == (fetch_pc >> (IB + 2)));
        e_tk  = e_hit && (m_ctr[k] >= 2);
        check("model_hit",    {31'd0, pred_hit},   {31'd0, e_hit});
        check("model_taken",  {31'd0, pred_taken}, {31'd0, e_tk});
        check("model_target", pred_target, e_tk ? m_tgt[k] : fetch_pc + 32'd4);
        check("model_br_cnt", br_cnt, m_br);
        check("model_miss",   miss_cnt, m_miss);
    end

    task automatic cyc();
        @(posedge CLK); #1;
    endtask

    task automatic look(input logic [31:0] pc);
        fetch_pc = pc; #1;
    endtask

    // One resolving branch, captured on the next edge; returns just after it.
    task automatic br_go(input logic [31:0] pc, input logic res, input logic [31:0] tgt,
                         input logic pred);
        br = 1; br_pc = pc; br_result = res; br_target = tgt; br_pred = pred;
        cyc();
        br = 0;
    endtask

    task automatic pred_is(input string name, input logic h, input logic t, input logic [31:0] tg);
        check({name, "_hit"},    {31'd0, pred_hit},   {31'd0, h});
        check({name, "_taken"},  {31'd0, pred_taken}, {31'd0, t});
        check({name, "_target"}, pred_target, tg);
    endtask

    localparam logic [31:0] PCS [4] = '{32'h48, 32'h88, 32'h4C, 32'h1048};

    initial begin
        nRST = 0; fetch_pc = 32'h48; br = 0; br_result = 0; br_pred = 0;
        br_pc = 0; br_target = 0; clear = 0;
        cyc(); cyc();
        // 1: reset state
        pred_is("reset", 0, 0, 32'h4C);
        check("reset_br_cnt", br_cnt, 0);
        check("reset_miss", miss_cnt, 0);
        nRST = 1;
        cyc();

        // 2: first taken branch allocates, visible through bypass next cycle
        br_go(32'h48, 1, 32'h100, 0);
        look(32'h48);
        pred_is("alloc_bypass", 1, 1, 32'h100);
        check("alloc_br_cnt", br_cnt, 1);
        check("alloc_miss", miss_cnt, 1);
        cyc();
        pred_is("alloc_written", 1, 1, 32'h100);

        // 3: saturate up, walk down, saturate at 0
        repeat (3) br_go(32'h48, 1, 32'h100, 1);
        br_go(32'h48, 0, 32'h0, 1);
        pred_is("ctr2", 1, 1, 32'h100);
        br_go(32'h48, 0, 32'h0, 1);
        pred_is("ctr1", 1, 0, 32'h4C);
        br_go(32'h48, 0, 32'h0, 1);
        br_go(32'h48, 0, 32'h0, 1);
        br_go(32'h48, 1, 32'h100, 1);
        pred_is("sat0_then_t", 1, 0, 32'h4C);
        br_go(32'h48, 1, 32'h100, 1);
        pred_is("back_to_2", 1, 1, 32'h100);

        // 4: aliasing into idx 2
        look(32'h88);
        pred_is("alias_miss", 0, 0, 32'h8C);
        br_go(32'h88, 0, 32'h0, 1);
        look(32'h48);
        pred_is("nt_no_alloc", 1, 1, 32'h100);
        br_go(32'h88, 1, 32'h200, 1);
        look(32'h48);
        pred_is("replaced_old", 0, 0, 32'h4C);
        look(32'h88);
        pred_is("replaced_new", 1, 1, 32'h200);

        // 5: back-to-back taken from ctr=1
        br_go(32'h88, 0, 32'h0, 1);
        pred_is("b2b_start", 1, 0, 32'h8C);
        br = 1; br_pc = 32'h88; br_result = 1; br_target = 32'h200; br_pred = 1;
        cyc();
        #1;
        pred_is("b2b_gap1", 1, 1, 32'h200);
        cyc();
        br = 0; #1;
        pred_is("b2b_gap2", 1, 1, 32'h200);
        br_go(32'h88, 0, 32'h0, 1);
        pred_is("b2b_final3", 1, 1, 32'h200);
        check("mid_br_cnt", br_cnt, 16);
        check("mid_miss", miss_cnt, 8);

        // 6: clear beats a same-cycle br; stats still count it
        clear = 1;
        br_go(32'h48, 1, 32'h300, 1);
        clear = 0;
        look(32'h48);
        pred_is("clear_48", 0, 0, 32'h4C);
        look(32'h88);
        pred_is("clear_88", 0, 0, 32'h8C);
        check("clear_br_cnt", br_cnt, 17);

        // nRST while an update is pending
        br_go(32'h48, 1, 32'h300, 1);
        look(32'h48);
        pred_is("pend_before_rst", 1, 1, 32'h300);
        nRST = 0; #1;
        pred_is("rst_pending", 0, 0, 32'h4C);
        check("rst_br_cnt", br_cnt, 0);
        #1 nRST = 1;
        cyc();
        pred_is("rst_after", 0, 0, 32'h4C);

        // Mixed traffic, checked by the model every cycle
        for (int i = 0; i < 400; i++) begin
            br        = ($urandom_range(0, 1) == 1);
            br_pc     = PCS[$urandom_range(0, 3)];
            br_result = ($urandom_range(0, 2) != 0);
            br_pred   = ($urandom_range(0, 1) == 1);
            br_target = {$urandom_range(0, 255), 2'b00} << 4;
            clear     = ($urandom_range(0, 29) == 0);
            fetch_pc  = PCS[$urandom_range(0, 3)];
            cyc();
        end
        br = 0; clear = 0;
        @(negedge CLK); #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Direct-mapped branch history table plus branch target buffer for the 5-stage MIPS pipeline.
- Sits beside the fetch stage and supplies the taken prediction and target the hazard unit carries down the pipeline as br_taken.
- Consumes the hazard unit's branch resolution pulse (br/br_result) to train 2-bit saturating counters and targets.
- Also keeps branch and mispredict statistics counters for the perf/debug interface.

Parameters:
- IDX_BITS, 4, index width; ENTRIES = 2**IDX_BITS.
- TAG_BITS, 30-IDX_BITS, derived, not overridable; tag = pc[31:IDX_BITS+2].

Ports:
- CLK  input  1  clock, rising edge.
- nRST  input  1  asynchronous, active-low reset.
- fetch_pc  input  32  PC currently in fetch.
- pred_hit  output  1  valid BTB entry with matching tag for fetch_pc.
- pred_taken  output  1  predicted taken (feeds br_taken path).
- pred_target  output  32  predicted next PC.
- br  input  1  one-cycle branch-resolved pulse, already qualified by ihit.
- br_result  input  1  actual outcome, 1 = taken.
- br_pred  input  1  prediction that was carried with the resolving branch.
- br_pc  input  32  PC of the resolving branch.
- br_target  input  32  computed taken target of the resolving branch.
- clear  input  1  synchronous invalidate of all entries.
- br_cnt  output  32  resolved-branch count.
- miss_cnt  output  32  mispredict count.

Behaviour:
- Entry fields: valid, tag[TAG_BITS-1:0], target[31:2], ctr[1:0].
- Address split: idx = pc[IDX_BITS+1:2]; tag = pc[31:IDX_BITS+2].
- Reset (async): all valid=0, all ctr=2'b01, all tags/targets=0, update register empty, br_cnt=0, miss_cnt=0.
- Lookup is combinational from fetch_pc, zero latency:
  - pred_hit = valid & (tag == fetch tag).
  - pred_taken = pred_hit & ctr[1].
  - pred_target = {target,2'b00} when pred_taken, else fetch_pc+4 (32-bit wrap).
- Predictions after reset: pred_hit=0, pred_taken=0, pred_target=fetch_pc+4.
- Update is pipelined, one stage:
  - On an edge with br=1: capture upd_v=1, idx, tag, result, target into the update register.
  - On the following edge: the table entry is written and upd_v clears, unless a new br is captured on that same edge.
- Write rules:
  - Hit (valid, tag match), taken: ctr saturating increment (max 3); target overwritten with br_target.
  - Hit, not taken: ctr saturating decrement (min 0); target unchanged.
  - Miss, taken: allocate: valid=1, new tag, target=br_target, ctr=2'b10.
  - Miss, not taken: no write; existing entry untouched.
- Bypass: while upd_v=1 and the fetch idx equals the pending idx, lookup uses the post-update entry value, never the stale table value.
- Back-to-back br pulses: each is written exactly once, in order. A second update to the same idx sees the first update's result.
- Statistics, updated on the edge where br=1:
  - br_cnt += 1.
  - miss_cnt += 1 when br_result != br_pred.
  - Both saturate at 32'hFFFF_FFFF.
- clear=1:
  - Next edge: all valid=0, all ctr=2'b01, any pending update dropped. Statistics unaffected.
  - clear and br in the same cycle: clear wins, br is not captured, but statistics still count it.
- nRST asserted mid-operation: pending update is discarded immediately; state returns to reset values.

Decomposition:
- Shared package bp_pkg holds:
  - bp_entry_t struct (valid, tag, target, ctr).
  - Counter constants SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11.
  - Index/tag extraction functions.
- One sub-module, bp_sat_ctr: combinational 2-bit saturating next-state (ctr, taken -> ctr_n).
- Table storage is flops, not SRAM.

Test Plan:
1. Reset, fetch_pc=0x48 -> pred_hit=0, pred_taken=0, pred_target=0x4C; br_cnt=0, miss_cnt=0.
2. br=1, br_pc=0x48, br_result=1, br_target=0x100, br_pred=0 -> next cycle (bypass) fetch 0x48 gives hit=1, taken=1, target=0x100; after write ctr=2; br_cnt=1, miss_cnt=1.
3. Three more taken updates to 0x48 -> ctr=3. Then:
   - first not-taken -> ctr=2, still taken to 0x100;
   - second not-taken -> ctr=1, pred_taken=0, pred_target=0x4C, pred_hit=1;
   - two further not-taken -> ctr saturates at 0.
4. Alias: fetch 0x88 (idx 2, tag 2) -> hit=0. Not-taken br at 0x88 -> no allocation, 0x48 still hits. Taken br at 0x88 -> replaces entry with ctr=2, and 0x48 now misses.
5. Back-to-back br pulses on consecutive cycles to idx 2 (taken, taken), starting from ctr=1 -> final ctr=3; fetch during each gap shows the bypassed value.
6. clear asserted together with a taken br -> next cycle all lookups hit=0, br_cnt still increments. Separately, nRST pulsed while upd_v=1 -> pending update lost, table invalid.
